// File: rtl/dft_scan_ctrl.sv
// Scan-out sequencer: captures DUT state, then shifts the scan chain out one
// word at a time through the SIPO buffer and hands each committed word to the
// host over a valid/ready port. The DUT clock is gated off whenever a word is
// waiting in the buffer or at the host, so the chain never loses a bit.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no pass in progress, all controls low
// CAPTURE | functional capture cycles with the DUT clock running
// ARM     | requesting a buffer operation, waiting for buf_op_ack
// SHIFT   | shifting one word of the chain into the buffer
// WAIT_C  | chain frozen, waiting for buf_op_commit
// OUT     | committed word presented to the host
// DONE    | one-cycle completion pulse
module dft_scan_ctrl #(
    parameter int unsigned CHAIN_LEN   = 256,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned CAP_CYCLES  = 1,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              dut_clk_en_o,
    output logic              sc_sen_o,
    output logic              buf_op_o,
    output logic              buf_val_op_o,
    output logic              buf_sin_sel_o,
    input  logic              buf_op_ack_i,
    input  logic              buf_op_commit_i,
    input  logic              buf_scaning_i,
    input  logic [WORD_W-1:0] dft_out_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_val_o,
    input  logic              out_rdy_i
);

    localparam int unsigned NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int unsigned BIT_W     = $clog2(WORD_W) + 1;
    localparam int unsigned WCNT_W    = $clog2(NUM_WORDS) + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_WORDS - 1);
    // tmo starts at 0 on state entry, so the last allowed cycle is N-1.
    localparam logic [3:0]        CAP_LAST  = 4'(CAP_CYCLES - 1);
    localparam logic [3:0]        TMO_LAST  = 4'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        ARM     = 3'd2,
        SHIFT   = 3'd3,
        WAIT_C  = 3'd4,
        OUT     = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [3:0]          tmo_q, tmo_d;
    logic                err_q, err_d;

    // State, counters and sticky error register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    // Next-state, counter and error update.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (tmo_q == CAP_LAST) state_d = ARM;
            end
            ARM: begin
                if (buf_op_ack_i) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // The buffer only reports scanning once it has seen sc_sen.
                if ((bit_cnt_q != '0) && !buf_scaning_i) err_d = 1'b1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_LAST) state_d = WAIT_C;
            end
            WAIT_C: begin
                if (buf_op_commit_i) begin
                    state_d = OUT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_rdy_i) begin
                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                    state_d    = (word_cnt_q == WORD_LAST) ? DONE : ARM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (buf_op_commit_i && (state_q != WAIT_C)) err_d = 1'b1;

        // Abort leaves the error flag exactly as it was.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = err_q;
        end

        if (state_d != state_q) tmo_d = '0;
        else if (tmo_q == 4'hF)  tmo_d = tmo_q;
        else                     tmo_d = tmo_q + 4'd1;
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy_o        = (state_q != IDLE);
        done_o        = 1'b0;
        dut_clk_en_o  = 1'b0;
        sc_sen_o      = 1'b0;
        buf_op_o      = 1'b0;
        buf_val_op_o  = 1'b0;
        buf_sin_sel_o = 1'b0;
        out_val_o     = 1'b0;
        unique case (state_q)
            CAPTURE: dut_clk_en_o = 1'b1;
            ARM:     buf_op_o     = 1'b1;
            SHIFT: begin
                dut_clk_en_o  = 1'b1;
                sc_sen_o      = 1'b1;
                buf_op_o      = 1'b1;
                buf_val_op_o  = 1'b1;
                buf_sin_sel_o = 1'b1;
            end
            OUT:     out_val_o    = 1'b1;
            DONE:    done_o       = 1'b1;
            default: ;
        endcase
    end

    assign err_o      = err_q;
    // The datapath only reloads on commit, so this is stable throughout OUT.
    assign out_data_o = dft_out_i;

endmodule

// File: tb/tb_dft_scan_ctrl.sv
`timescale 1ns/1ps
module tb_dft_scan_ctrl;

    localparam int WORD_W = 32;
    localparam int NWORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic        busy, done, err;
    logic        dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel;
    logic        ack, buf_op_commit, scaning;
    logic [31:0] dft_out, out_data;
    logic        out_val, out_rdy;

    int errors = 0;
    int checks = 0;

    int sc_count = 0;
    int done_cnt = 0;
    int words_out = 0;
    int commits = 0;
    logic [31:0] exp_q[$];

    int ack_delay = 0;
    int commit_delay = 0;
    bit ack_en = 1'b1;
    bit commit_en = 1'b1;
    bit stray_req = 1'b0;

    dft_scan_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .abort_i         (abort),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .dut_clk_en_o    (dut_clk_en),
        .sc_sen_o        (sc_sen),
        .buf_op_o        (buf_op),
        .buf_val_op_o    (buf_val_op),
        .buf_sin_sel_o   (buf_sin_sel),
        .buf_op_ack_i    (ack),
        .buf_op_commit_i (buf_op_commit),
        .buf_scaning_i   (scaning),
        .dft_out_i       (dft_out),
        .out_data_o      (out_data),
        .out_val_o       (out_val),
        .out_rdy_i       (out_rdy)
    );

    always #5 clk = ~clk;

    // Buffer/datapath model: answers ack and commit, loads dft_out from the
    // number of bits physically shifted, and pushes the expected word.
    initial begin : responder
        int  arm_age;
        int  wc_age;
        bit  load_pending;
        bit  wait_c;
        arm_age = 0;
        wc_age = 0;
        load_pending = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (load_pending) begin
                dft_out = 32'hA5A5_0000 + 32'(sc_count / WORD_W) - 32'd1;
                load_pending = 1'b0;
            end
            ack = (buf_op && !sc_sen && ack_en && (arm_age >= ack_delay));
            if (buf_op && !sc_sen) arm_age++;
            else arm_age = 0;
            wait_c = busy && !dut_clk_en && !buf_op && !out_val && !done;
            buf_op_commit = 1'b0;
            if (wait_c && commit_en && (wc_age >= commit_delay)) begin
                buf_op_commit = 1'b1;
                load_pending = 1'b1;
                exp_q.push_back(32'hA5A5_0000 + 32'(commits));
                commits++;
            end
            if (wait_c) wc_age++;
            else wc_age = 0;
            if (stray_req) buf_op_commit = 1'b1;
            scaning = sc_sen;
        end
    end

    // Scoreboard and event counters.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst_n) begin
            if (sc_sen && dut_clk_en) sc_count++;
            if (done) done_cnt++;
            if (out_val && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: out_data=%h but no word was committed", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL word_data: out_data=%h expected %h", out_data, exp_w);
                    end
                end
                words_out++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        exp_q.delete();
        sc_count = 0;
        done_cnt = 0;
        words_out = 0;
        commits = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (!done && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    task automatic check_pass_end(input string tag, input bit exp_err);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt);
        end
        checks++;
        if (words_out !== NWORDS) begin
            errors++;
            $display("FAIL %s_words: got %0d expected %0d", tag, words_out, NWORDS);
        end
        checks++;
        if (sc_count !== 256) begin
            errors++;
            $display("FAIL %s_shift_cycles: got %0d expected 256", tag, sc_count);
        end
        checks++;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d busy=%b expected 0 0", tag, exp_q.size(), busy);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %b expected %b", tag, err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, err, out_val} !== 4'b0) begin
            errors++;
            $display("FAIL reset_status: busy/done/err/out_val=%b expected 0000", {busy, done, err, out_val});
        end
        checks++;
        if ({dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel} !== 5'b0) begin
            errors++;
            $display("FAIL reset_controls: got %b expected 00000", {dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_pass();
        int n;
        ack_delay = 1;
        commit_delay = 1;
        out_rdy = 1'b1;
        do_start();
        checks++;
        if ({busy, dut_clk_en, sc_sen, buf_op} !== 4'b1100) begin
            errors++;
            $display("FAIL capture_outputs: busy/clk_en/sen/op=%b expected 1100", {busy, dut_clk_en, sc_sen, buf_op});
        end
        step();
        checks++;
        if ({buf_op, dut_clk_en, sc_sen} !== 3'b100) begin
            errors++;
            $display("FAIL arm_entry: op/clk_en/sen=%b expected 100", {buf_op, dut_clk_en, sc_sen});
        end
        wait_done(1000, n);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL full_done_seen: done=%b after %0d cycles expected 1", done, n);
        end
        step();
        check_pass_end("full", 1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        int sc0;
        logic [31:0] d0;
        ack_delay = 0;
        commit_delay = 0;
        out_rdy = 1'b1;
        do_start();
        n = 0;
        while (words_out < 3 && n < 500) begin
            step();
            n++;
        end
        out_rdy = 1'b0;
        n = 0;
        while (!out_val && n < 100) begin
            step();
            n++;
        end
        @(negedge clk);
        #1;
        d0 = out_data;
        sc0 = sc_count;
        checks++;
        if (d0 !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL stall_word: out_data=%h expected a5a50003", d0);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (out_val !== 1'b1 || dut_clk_en !== 1'b0 || out_data !== d0 || sc_count !== sc0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable cycles expected 0", bad);
        end
        step();
        out_rdy = 1'b1;
        wait_done(1000, n);
        step();
        check_pass_end("stall", 1'b0);
    endtask

    task automatic test_ack_timeout();
        int n;
        ack_en = 1'b0;
        do_start();
        n = 0;
        while (!buf_op && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (buf_op && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL ack_timeout_len: ARM lasted %0d cycles expected 8", n);
        end
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ack_timeout_state: err/busy=%b expected 10", {err, busy});
        end
        ack_en = 1'b1;
    endtask

    task automatic test_abort();
        int n;
        ack_delay = 0;
        commit_delay = 0;
        do_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err: got %b expected 0", err);
        end
        n = 0;
        while (!sc_sen && n < 20) begin
            step();
            n++;
        end
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy, dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel, out_val, done} !== 8'b0) begin
            errors++;
            $display("FAIL abort_controls: got %b expected 00000000",
                     {busy, dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel, out_val, done});
        end
        checks++;
        if (sc_count !== 10) begin
            errors++;
            $display("FAIL abort_shifts: got %0d expected 10", sc_count);
        end
        repeat (5) step();
        checks++;
        if ({done_cnt != 0, busy, err} !== 3'b000) begin
            errors++;
            $display("FAIL abort_quiet: done_cnt=%0d busy=%b err=%b expected 0 0 0", done_cnt, busy, err);
        end
    endtask

    task automatic test_async_reset();
        int n;
        ack_delay = 0;
        commit_delay = 0;
        commit_en = 1'b0;
        do_start();
        n = 0;
        while (!(busy && !dut_clk_en && !buf_op && !out_val && !done) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if ({busy, sc_count} !== {1'b1, 32'd32}) begin
            errors++;
            $display("FAIL wait_c_reached: busy=%b shifts=%0d expected 1 32", busy, sc_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, err, done, out_val, dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected 000000000",
                     {busy, err, done, out_val, dut_clk_en, sc_sen, buf_op, buf_val_op, buf_sin_sel});
        end
        step();
        step();
        rst_n = 1'b1;
        commit_en = 1'b1;
        step();
        do_start();
        wait_done(1000, n);
        checks++;
        if (n !== 281) begin
            errors++;
            $display("FAIL pass_latency: done after %0d cycles expected 281", n);
        end
        step();
        check_pass_end("post_reset", 1'b0);
    endtask

    task automatic test_stray_commit();
        int n;
        ack_delay = 0;
        commit_delay = 0;
        do_start();
        n = 0;
        while (!sc_sen && n < 20) begin
            step();
            n++;
        end
        repeat (4) step();
        stray_req = 1'b1;
        step();
        stray_req = 1'b0;
        checks++;
        if ({err, sc_sen} !== 2'b11) begin
            errors++;
            $display("FAIL stray_err: err/sen=%b expected 11", {err, sc_sen});
        end
        n = 0;
        while (sc_sen && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sc_count !== 32) begin
            errors++;
            $display("FAIL stray_shift_count: got %0d expected 32", sc_count);
        end
        wait_done(1000, n);
        step();
        check_pass_end("stray", 1'b1);
    endtask

    initial begin
        start = 1'b0;
        abort = 1'b0;
        out_rdy = 1'b1;
        ack = 1'b0;
        buf_op_commit = 1'b0;
        scaning = 1'b0;
        dft_out = 32'h0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_full_pass();
        test_backpressure();
        test_ack_timeout();
        test_abort();
        test_async_reset();
        test_stray_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
